// File: rtl/sub_pkg.sv
//==============================================================================
// Module      : sub_pkg
// Description : Shared FSM state encoding for the bit-serial subtractor.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package sub_pkg;

    localparam int c_STATE_W = 2;

    typedef enum logic [c_STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/full_subtractor.sv
//==============================================================================
// Module      : full_subtractor
// Description : Single-bit full subtractor cell, d = x - y - bi.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//==============================================================================
// Module      : serial_subtractor
// Description : LSB-first bit-serial subtractor, one result bit per RUN cycle.
//               Define SUB_OVF_EN to add the signed-overflow output ovf.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int c_CNT_W = $clog2(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_res;
    logic [WIDTH-1:0]     r_diff;
    logic                 r_bw;
    logic                 r_borrow;
    logic                 r_done;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 w_d;
    logic                 w_bo;
    logic                 w_last;

    full_subtractor u_fs (
        .x  (r_a[0]),
        .y  (r_b[0]),
        .bi (r_bw),
        .d  (w_d),
        .bo (w_bo)
    );

    assign w_last = (r_cnt == c_CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands shift right so the cell always sees bit 0; the result fills from the MSB end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_bw     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_bw  <= bin;
                        r_res <= '0;
                        r_cnt <= '0;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_bw  <= w_bo;
                    r_res <= {w_d, r_res[WIDTH-1:1]};
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                DONE: begin
                    r_diff   <= r_res;
                    r_borrow <= r_bw;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_OVF_EN
    // Operand signs are shifted out during RUN, so keep copies for the overflow test.
    logic r_sa;
    logic r_sb;
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa  <= 1'b0;
            r_sb  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            if (r_state == IDLE && start) begin
                r_sa <= a[WIDTH-1];
                r_sb <= b[WIDTH-1];
            end
            if (r_state == DONE) begin
                r_ovf <= (r_sa ^ r_sb) & (r_res[WIDTH-1] ^ r_sa);
            end
        end
    end

    assign ovf = r_ovf;
`endif

    assign ready  = (r_state == IDLE);
    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign done   = r_done;

endmodule

`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request; accepted only when ready=1.
REQ-005 SHALL have port: a  input  WIDTH  minuend, sampled on accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, sampled on accepted start.
REQ-007 SHALL have port: bin  input  1  borrow-in, sampled on accepted start.
REQ-008 SHALL have port: ready  output  1  high only in IDLE.
REQ-009 SHALL have port: diff  output  WIDTH  registered result (a - b - bin) mod 2^WIDTH.
REQ-010 SHALL have port: borrow  output  1  registered borrow-out, 1 when a < b + bin (unsigned).
REQ-011 SHALL have port: done  output  1  single-cycle pulse marking diff/borrow valid.
REQ-012 SHALL have port (only with SUB_OVF_EN): ovf  output  1  signed two's-complement overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL move IDLE->RUN on start=1 at a rising edge, capturing a, b, bin into shift registers and clearing the bit counter.
REQ-015 SHALL, in RUN, compute exactly one result bit per cycle, LSB first, via one full-subtractor cell with a registered borrow chain.
REQ-016 SHALL move RUN->DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1).
REQ-017 SHALL, in DONE, assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL give latency: start sampled at edge N -> done high during cycle after edge N+WIDTH+1; diff/borrow valid with done.
REQ-019 SHALL hold diff/borrow (and ovf) stable from done until the next done; shift-register internals SHALL NOT be visible on outputs mid-operation.
REQ-020 SHALL ignore start while in RUN or DONE (ready=0); no queuing, no corruption of the operation in flight.
REQ-021 SHALL accept start asserted in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).
REQ-022 SHALL produce correct results at all boundaries: a=b with bin=0 -> 0/borrow 0; a=0, b=2^WIDTH-1, bin=1 -> diff 0, borrow 1.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-RUN, asynchronously force IDLE, ready=1, diff=0, borrow=0, done=0, ovf=0, counter and shift registers 0.
REQ-024 SHALL discard any operation in flight at reset; no done pulse for it after release.

Configuration
REQ-025 SHALL, with macro SUB_OVF_EN defined, provide port ovf = 1 when sign(a) != sign(b) and sign(diff) != sign(a), registered and updated with done.
REQ-026 SHALL, without SUB_OVF_EN, omit the ovf port and its logic entirely; all other behaviour identical.

Structure
REQ-027 SHALL place the FSM state enum (IDLE/RUN/DONE) and the state-width constant in shared package sub_pkg.
REQ-028 SHALL instantiate one combinational sub-module full_subtractor (inputs x, y, bi; outputs d, bo) for the per-bit step.

Verification (WIDTH=4)
REQ-029 SHALL check a=1000, b=0011, bin=0, start pulse -> diff=0101, borrow=0, done exactly 6 edges after start edge, ready low throughout.
REQ-030 SHALL check a=0001, b=1010, bin=1 -> diff=0110, borrow=1; then a=0110, b=0110, bin=0 back-to-back -> diff=0000, borrow=0.
REQ-031 SHALL check with SUB_OVF_EN a=0111, b=1110, bin=0 -> diff=1001, borrow=1, ovf=1; a=1001, b=0100 -> diff=0101, borrow=0, ovf=1.
REQ-032 SHALL check start re-asserted with a=1111, b=0001 during RUN of a=1001, b=0110, bin=1 -> only diff=0010, borrow=0 reported, one done pulse.
REQ-033 SHALL check rst_n pulsed low during the 2nd RUN cycle -> outputs 0, ready=1 immediately, no done for aborted operation; next start a=1111, b=1110, bin=1 -> diff=0000, borrow=0.
